band_accum_sched: RTL and testbench

Frame scheduler and two-way arbiter for the shared band-energy accumulator. Two spectral-frame sources request the accumulator. The block grants one source per frame (round-robin) and clears the accumulator with a one-cycle synchronous reset. It then forwards exactly FRAME_LEN beats as an `in_en`-qualified stream, waits for the accumulator's `out_en` dump, and reports completion with the source id or a timeout error.

---
 rtl/band_accum_sched.sv | 166 ++++++++++++++++
 tb/tb_band_accum_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/band_accum_sched.sv
// Frame scheduler and two-way round-robin arbiter for the shared band-energy
// accumulator. One source is granted per frame. The accumulator is cleared,
// then exactly FRAME_LEN beats are forwarded, and the scheduler waits for the
// dump strobe or a timeout before reporting completion.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | no frame in flight; arbitrate between req0/req1
//   S_CLEAR  | grant held; pulse acc_rst for one cycle, clear beat count
//   S_STREAM | forward handshaked beats of the granted source
//   S_WAIT   | all beats sent; wait for acc_out_en or timeout
//   S_DONE   | one-cycle completion report; grant already released
module band_accum_sched #(
    parameter int DW        = 31,
    parameter int FRAME_LEN = 114,
    parameter int TIMEOUT   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    output logic          gnt0,
    output logic          gnt1,
    input  logic [DW-1:0] s_data0,
    input  logic [DW-1:0] s_data1,
    input  logic          s_valid0,
    input  logic          s_valid1,
    output logic          s_ready0,
    output logic          s_ready1,
    output logic [DW-1:0] acc_din,
    output logic          acc_in_en,
    output logic          acc_rst,
    input  logic          acc_out_en,
    output logic          busy,
    output logic          done,
    output logic          done_id,
    output logic          err
);

    localparam int BEAT_W = $clog2(FRAME_LEN + 1);
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state;
    logic                id;
    logic                last_id;
    logic [1:0]          gnt;
    logic [1:0]          rdy;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [WAIT_W-1:0]   wait_cnt;

    logic                arb_id;
    logic                sel_valid;
    logic [DW-1:0]       sel_data;
    logic                hs;
    logic                last_beat;
    logic                wait_expired;

    assign gnt0     = gnt[0];
    assign gnt1     = gnt[1];
    assign s_ready0 = rdy[0];
    assign s_ready1 = rdy[1];

    // Arbitration winner: on a tie the source not served last wins.
    always_comb begin
        arb_id = 1'b0;
        if (req0 && req1) begin
            arb_id = ~last_id;
        end else if (req1) begin
            arb_id = 1'b1;
        end
    end

    // Granted-source mux and handshake qualification.
    always_comb begin
        sel_valid    = id ? s_valid1 : s_valid0;
        sel_data     = id ? s_data1  : s_data0;
        hs           = (|rdy) && sel_valid;
        last_beat    = (beat_cnt == BEAT_W'(FRAME_LEN - 1));
        wait_expired = (wait_cnt == WAIT_W'(TIMEOUT - 1));
    end

    // Frame sequencing FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            id        <= 1'b0;
            last_id   <= 1'b1;
            gnt       <= 2'b00;
            rdy       <= 2'b00;
            beat_cnt  <= '0;
            wait_cnt  <= '0;
            acc_din   <= '0;
            acc_in_en <= 1'b0;
            acc_rst   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            done_id   <= 1'b0;
            err       <= 1'b0;
        end else begin
            acc_in_en <= 1'b0;
            acc_rst   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        id    <= arb_id;
                        gnt   <= {arb_id, ~arb_id};
                        busy  <= 1'b1;
                        state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    acc_rst  <= 1'b1;
                    beat_cnt <= '0;
                    wait_cnt <= '0;
                    state    <= S_STREAM;
                end
                S_STREAM: begin
                    if (hs) begin
                        acc_din   <= sel_data;
                        acc_in_en <= 1'b1;
                        beat_cnt  <= beat_cnt + 1'b1;
                    end
                    // Ready drops right after the final beat so no extra beat slips in.
                    if (hs && last_beat) begin
                        rdy      <= 2'b00;
                        wait_cnt <= '0;
                        state    <= S_WAIT;
                    end else begin
                        rdy <= {id, ~id};
                    end
                end
                S_WAIT: begin
                    if (acc_out_en || wait_expired) begin
                        done    <= 1'b1;
                        done_id <= id;
                        err     <= ~acc_out_en;
                        gnt     <= 2'b00;
                        last_id <= id;
                        state   <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    done_id <= 1'b0;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_band_accum_sched.sv
// Directed-plus-random bench for band_accum_sched. The reference model tracks
// round-robin ownership, the ordered list of beats a source offers, and the
// cycle-level timing of grant, clear, stream, wait and completion.
module tb_band_accum_sched;

    localparam int DW        = 31;
    localparam int FRAME_LEN = 114;
    localparam int TIMEOUT   = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1;
    logic          gnt0, gnt1;
    logic [DW-1:0] s_data0, s_data1;
    logic          s_valid0, s_valid1;
    logic          s_ready0, s_ready1;
    logic [DW-1:0] acc_din;
    logic          acc_in_en;
    logic          acc_rst;
    logic          acc_out_en;
    logic          busy, done, done_id, err;

    int checks = 0;
    int errors = 0;
    int last_served = 1;
    logic [DW-1:0] exp_din = '0;

    always #5 clk = ~clk;

    band_accum_sched #(.DW(DW), .FRAME_LEN(FRAME_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0       (req0),
        .req1       (req1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .s_data0    (s_data0),
        .s_data1    (s_data1),
        .s_valid0   (s_valid0),
        .s_valid1   (s_valid1),
        .s_ready0   (s_ready0),
        .s_ready1   (s_ready1),
        .acc_din    (acc_din),
        .acc_in_en  (acc_in_en),
        .acc_rst    (acc_rst),
        .acc_out_en (acc_out_en),
        .busy       (busy),
        .done       (done),
        .done_id    (done_id),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic r0, input logic r1);
        if (r0 && r1) return 1 - last_served;
        if (r0) return 0;
        return 1;
    endfunction

    task automatic drive(input int ch, input logic v, input logic [DW-1:0] d,
                         input logic [DW-1:0] junk);
        if (ch == 0) begin
            s_valid0 = v;    s_data0 = d;
            s_valid1 = 1'b1; s_data1 = junk;
        end else begin
            s_valid1 = v;    s_data1 = d;
            s_valid0 = 1'b1; s_data0 = junk;
        end
    endtask

    // mode: 0 = contiguous beat index, 1 = valid toggling, 2 = random gaps/data
    task automatic run_frame(input int mode, input bit timeout, input bit drop_req,
                             input int abort_at);
        int id, beats, cyc, lat;
        logic v;
        logic [DW-1:0] d;
        logic [1:0] oh;
        id = pick(req0, req1);
        oh = (id == 0) ? 2'b01 : 2'b10;

        tick();
        chk("grant", 64'({gnt1, gnt0}), 64'(oh));
        chk("acc_rst_at_grant", 64'(acc_rst), 64'(0));
        chk("busy_at_grant", 64'(busy), 64'(1));
        chk("ready_at_grant", 64'({s_ready1, s_ready0}), 64'(0));
        if (drop_req) begin
            if (id == 0) req0 = 1'b0; else req1 = 1'b0;
        end
        acc_out_en = 1'b1;

        tick();
        chk("acc_rst_clear", 64'(acc_rst), 64'(1));
        chk("ready_clear", 64'({s_ready1, s_ready0}), 64'(0));
        chk("in_en_clear", 64'(acc_in_en), 64'(0));
        acc_out_en = 1'b0;

        tick();
        chk("acc_rst_drop", 64'(acc_rst), 64'(0));
        chk("ready_stream", 64'({s_ready1, s_ready0}), 64'(oh));

        beats = 0;
        cyc   = 0;
        while (beats < FRAME_LEN && cyc < 4000) begin
            if (abort_at > 0 && beats == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("abort_gnt", 64'({gnt1, gnt0}), 64'(0));
                chk("abort_ready", 64'({s_ready1, s_ready0}), 64'(0));
                chk("abort_in_en", 64'(acc_in_en), 64'(0));
                chk("abort_acc_rst", 64'(acc_rst), 64'(1));
                chk("abort_done", 64'(done), 64'(0));
                chk("abort_busy", 64'(busy), 64'(0));
                exp_din     = '0;
                last_served = 1;
                drive(id, 1'b0, '0, '0);
                return;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = ((cyc % 2) == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            d = (mode == 0) ? DW'(beats) : DW'($urandom);
            drive(id, v, d, DW'($urandom));
            acc_out_en = 1'($urandom_range(0, 1));
            tick();
            cyc++;
            chk("in_en", 64'(acc_in_en), 64'(v));
            if (v) begin
                exp_din = d;
                beats++;
            end
            chk("din", 64'(acc_din), 64'(exp_din));
            chk("acc_rst_stream", 64'(acc_rst), 64'(0));
            chk("done_stream", 64'(done), 64'(0));
            chk("gnt_onehot", 64'(gnt0 & gnt1), 64'(0));
            if (beats < FRAME_LEN)
                chk("ready", 64'({s_ready1, s_ready0}), 64'(oh));
            else
                chk("ready_drop", 64'({s_ready1, s_ready0}), 64'(0));
        end
        chk("beat_count", 64'(beats), 64'(FRAME_LEN));
        if (mode == 0) chk("stream_cycles", 64'(cyc), 64'(FRAME_LEN));
        if (mode == 1) chk("stream_cycles", 64'(cyc), 64'(2 * FRAME_LEN - 1));
        drive(id, 1'b0, '0, '0);
        acc_out_en = 1'b0;

        if (timeout) begin
            for (int i = 0; i < TIMEOUT - 1; i++) begin
                tick();
                chk("done_early", 64'(done), 64'(0));
                chk("gnt_wait", 64'({gnt1, gnt0}), 64'(oh));
            end
            tick();
            chk("err", 64'(err), 64'(1));
        end else begin
            lat = $urandom_range(0, 3);
            for (int i = 0; i < lat; i++) begin
                tick();
                chk("done_early", 64'(done), 64'(0));
            end
            acc_out_en = 1'b1;
            tick();
            acc_out_en = 1'b0;
            chk("err", 64'(err), 64'(0));
        end
        chk("done", 64'(done), 64'(1));
        chk("done_id", 64'(done_id), 64'(id));
        chk("gnt_release", 64'({gnt1, gnt0}), 64'(0));
        chk("busy_done", 64'(busy), 64'(1));
        last_served = id;

        tick();
        chk("done_pulse", 64'(done), 64'(0));
        chk("err_clear", 64'(err), 64'(0));
        chk("busy_idle", 64'(busy), 64'(0));
    endtask

    initial begin
        rst_n = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        s_data0 = '0; s_data1 = '0; s_valid0 = 1'b0; s_valid1 = 1'b0;
        acc_out_en = 1'b0;
        #2 rst_n = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("rst_acc_rst", 64'(acc_rst), 64'(1));
        chk("rst_gnt", 64'({gnt1, gnt0}), 64'(0));
        chk("rst_ready", 64'({s_ready1, s_ready0}), 64'(0));
        chk("rst_in_en", 64'(acc_in_en), 64'(0));
        chk("rst_din", 64'(acc_din), 64'(0));
        chk("rst_status", 64'({busy, done, done_id, err}), 64'(0));
        rst_n = 1'b1;

        // contiguous ch0 frame, then ties alternate ch1, ch0
        run_frame(0, 1'b0, 1'b0, 0);
        run_frame(2, 1'b0, 1'b0, 0);
        run_frame(2, 1'b0, 1'b0, 0);

        // ch1 alone with valid toggling every cycle
        req0 = 1'b0; req1 = 1'b1;
        run_frame(1, 1'b0, 1'b0, 0);

        // ch0 timeout with request dropped after grant, then ch1 served normally
        req0 = 1'b1; req1 = 1'b0;
        run_frame(2, 1'b1, 1'b1, 0);
        req1 = 1'b1;
        run_frame(2, 1'b0, 1'b0, 0);

        // reset after beat 50, then a fresh frame
        req0 = 1'b1; req1 = 1'b1;
        run_frame(0, 1'b0, 1'b0, 50);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_hold_done", 64'(done), 64'(0));
            chk("rst_hold_acc_rst", 64'(acc_rst), 64'(1));
        end
        rst_n = 1'b1;
        run_frame(0, 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
